// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field codes, FSM states and the
// registered control bundle.
package decode_pkg;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    localparam logic [2:0] F1_LI  = 3'b000;
    localparam logic [2:0] F1_B   = 3'b100;
    localparam logic [2:0] F1_BCC = 3'b111;

    localparam logic [3:0] OP_NOWB  = 4'b0101;
    localparam logic [3:0] OP_LI    = 4'b0110;
    localparam logic [3:0] OP_RSV0  = 4'b0111;
    localparam logic [3:0] OP_SH_LO = 4'b1000;
    localparam logic [3:0] OP_SH_HI = 4'b1011;
    localparam logic [3:0] OP_IN    = 4'b1100;
    localparam logic [3:0] OP_OUT   = 4'b1101;
    localparam logic [3:0] OP_RSV1  = 4'b1110;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    localparam logic [2:0] BR_ALWAYS = 3'b100;
    localparam logic [2:0] BR_NONE   = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src1;
        logic       alu_src2;
        logic       mem_to_reg;
        logic       in_en;
        logic       out_en;
        logic       alu_or_shift;
        logic       branch_cond;
        logic       as_bc;
        logic       halt;
        logic [3:0] opcode;
        logic [2:0] reg_dst;
        logic [2:0] branch;
    } ctl_t;

    function automatic ctl_t ctl_reset();
        ctl_t c;
        c        = '0;
        c.branch = BR_NONE;
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register load-use scoreboard: a down-counter per register, armed by
// accepted loads, and the source-operand hazard check against it.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int NREG     = 8,
    parameter int LOAD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_i,
    input  logic [$clog2(NREG)-1:0] set_idx_i,
    input  logic                    rd1_en_i,
    input  logic [$clog2(NREG)-1:0] rd1_idx_i,
    input  logic                    rd2_en_i,
    input  logic [$clog2(NREG)-1:0] rd2_idx_i,
    output logic                    hazard_o
);

    localparam int RW = $clog2(NREG);

    logic [NREG-1:0] busy;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            logic [2:0] cnt_q;
            logic [2:0] cnt_d;

            // A fresh load re-arms the counter even if it is still counting.
            always_comb begin
                cnt_d = cnt_q;
                if (set_i && (set_idx_i == RW'(gi))) begin
                    cnt_d = 3'(LOAD_LAT);
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= 3'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign busy[gi] = (cnt_q != 3'd0);
        end
    endgenerate

    assign hazard_o = (rd1_en_i & busy[rd1_idx_i]) | (rd2_en_i & busy[rd2_idx_i]);

endmodule

// File: rtl/decode_ctl.sv
// Instruction decode with a one-deep registered control bundle, load-use
// interlock and halt FSM. Macro DECODE_CTL_IO_EN enables the IN/OUT ops.
module decode_ctl
    import decode_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int NREG     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic        mem_to_reg,
    output logic        in_en,
    output logic        out_en,
    output logic        alu_or_shift,
    output logic        branch_cond,
    output logic        as_bc,
    output logic        halt,
    output logic [3:0]  opcode,
    output logic [2:0]  reg_dst,
    output logic [2:0]  branch,
    output logic        halted
);

    localparam int RW = $clog2(NREG);

    logic [1:0] cls;
    logic [3:0] op;
    logic [2:0] f1;
    logic [2:0] f2;
    logic       unused_low;

    assign cls        = inst[15:14];
    assign f1         = inst[13:11];
    assign f2         = inst[10:8];
    assign op         = inst[7:4];
    assign unused_low = ^inst[3:0];

    ctl_t   dec;
    logic   rd1_en;
    logic   rd2_en;
    logic   hazard;
    logic   accept;
    logic   run_st;
    ctl_t   bundle_q, bundle_d;
    logic   out_valid_q, out_valid_d;
    logic   rdy_q;
    state_t state_q, state_d;

    always_comb begin
        dec          = '0;
        dec.branch   = BR_NONE;
        dec.alu_src2 = 1'b1;
        dec.reg_dst  = f2;
        rd1_en       = 1'b0;
        rd2_en       = 1'b0;
        case (cls)
            CLS_LD: begin
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_dst    = f1;
                rd2_en         = 1'b1;
            end
            CLS_ST: begin
                dec.mem_write = 1'b1;
                rd1_en        = 1'b1;
                rd2_en        = 1'b1;
            end
            CLS_BR: begin
                dec.alu_src1 = (f1 != F1_LI);
                if (f1 == F1_LI) begin
                    dec.reg_write = 1'b1;
                    dec.opcode    = OP_LI;
                end else if (f1 == F1_B) begin
                    dec.branch      = BR_ALWAYS;
                    dec.branch_cond = 1'b1;
                end else if (f1 == F1_BCC) begin
                    dec.branch      = f2;
                    dec.branch_cond = 1'b1;
                end
            end
            default: begin
                rd1_en           = 1'b1;
                rd2_en           = 1'b1;
                dec.opcode       = op;
                dec.alu_src2     = (op > OP_LI);
                dec.reg_write    = !(op == OP_NOWB || op == OP_RSV0 || op == OP_OUT ||
                                     op == OP_RSV1 || op == OP_HLT);
                dec.alu_or_shift = (op >= OP_SH_LO) && (op <= OP_SH_HI);
                dec.halt         = (op == OP_HLT);
                dec.as_bc        = !(op == OP_RSV0 || op == OP_IN || op == OP_OUT ||
                                     op == OP_RSV1 || op == OP_HLT);
`ifdef DECODE_CTL_IO_EN
                dec.in_en        = (op == OP_IN);
                dec.mem_to_reg   = (op == OP_IN);
                dec.out_en       = (op == OP_OUT);
`else
                // Without the IO port, IN must not write back a stale value.
                if (op == OP_IN) begin
                    dec.reg_write = 1'b0;
                end
`endif
            end
        endcase
    end

    decode_scoreboard #(
        .NREG     (NREG),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (accept & dec.mem_read),
        .set_idx_i (f1[RW-1:0]),
        .rd1_en_i  (rd1_en),
        .rd1_idx_i (f1[RW-1:0]),
        .rd2_en_i  (rd2_en),
        .rd2_idx_i (f2[RW-1:0]),
        .hazard_o  (hazard)
    );

    assign in_ready = rdy_q & run_st & !flush & !hazard & (!out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // rdy_q keeps in_ready low for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= ctl_reset();
            rdy_q       <= 1'b0;
            state_q     <= ST_RUN;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            rdy_q       <= 1'b1;
            state_q     <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && dec.halt) begin
                    state_d = ST_HALT_PEND;
                end
            end
            ST_HALT_PEND: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (out_valid_q && out_ready) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        run_st = (state_q == ST_RUN);
        halted = (state_q == ST_HALTED);
    end

    assign out_valid    = out_valid_q;
    assign mem_read     = bundle_q.mem_read;
    assign mem_write    = bundle_q.mem_write;
    assign reg_write    = bundle_q.reg_write;
    assign alu_src1     = bundle_q.alu_src1;
    assign alu_src2     = bundle_q.alu_src2;
    assign mem_to_reg   = bundle_q.mem_to_reg;
    assign in_en        = bundle_q.in_en;
    assign out_en       = bundle_q.out_en;
    assign alu_or_shift = bundle_q.alu_or_shift;
    assign branch_cond  = bundle_q.branch_cond;
    assign as_bc        = bundle_q.as_bc;
    assign halt         = bundle_q.halt;
    assign opcode       = bundle_q.opcode;
    assign reg_dst      = bundle_q.reg_dst;
    assign branch       = bundle_q.branch;

endmodule

// File: doc/decode_ctl.md
DECODE_CTL -- requirements
Module: decode_ctl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 2, range 1..7: cycles a loaded register stays unreadable after its LD is accepted.
REQ-002 SHALL have parameter NREG, default 8: register count; source and destination fields are clog2(NREG) bits wide.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 inst  in  16  instruction word.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-007 out_valid / out_ready  out / in  1 / 1  control-bundle handshake.
REQ-008 flush  in  1  kill the unconsumed bundle (taken branch).
REQ-009 bundle outputs: mem_read, mem_write, reg_write, alu_src1, alu_src2, mem_to_reg, in_en, out_en, alu_or_shift, branch_cond, as_bc, halt (1 each); opcode [3:0]; reg_dst [2:0]; branch [2:0].
REQ-010 halted  out  1  sticky halt status.

Function
REQ-011 Decode SHALL use class=inst[15:14], op=inst[7:4], f1=inst[13:11], f2=inst[10:8]: 00 LD, 01 ST, 10 LI(f1=000)/B(f1=100)/Bcc(f1=111), 11 ALU/shift/IO/HLT.
REQ-012 reg_write=1 for LD, LI, and class 11 with op not in {0101,0111,1101,1110,1111}; mem_read=LD; mem_write=ST; mem_to_reg=LD or IN; alu_src1=class 10 with f1!=000.
REQ-013 alu_src2=0 only for class 11 with op 0000..0110; alu_or_shift=class 11 with op 1000..1011; in_en=op 1100; out_en=op 1101; halt=op 1111 (all class 11).
REQ-014 opcode=op for class 11, 0110 for LI, else 0000; reg_dst=f1 for LD, else f2.
REQ-015 branch=f2 with branch_cond=1 for Bcc; branch=100 with branch_cond=1 for B; else branch=111, branch_cond=0.
REQ-016 as_bc=class 11 with op not in {0111,1100,1101,1110,1111}.
REQ-017 Sources: ST and class 11 read f1 and f2; LD reads f2; LI, B, Bcc read none.
REQ-018 Output bundle SHALL be one register stage: loaded on in_valid&in_ready; latency exactly 1 cycle.
REQ-019 in_ready = state RUN & !flush & !hazard & (!out_valid | out_ready).
REQ-020 out_valid SHALL clear when out_ready accepts with no new load, or on flush; bundle fields hold while out_valid&!out_ready.
REQ-021 Scoreboard: per-register down-counter; accepted LD sets counter[f1]=LOAD_LAT; non-zero counters decrement each cycle, saturating at 0.
REQ-022 hazard=1 when any source of inst has counter>0; a register set and read in the same cycle counts as pending.
REQ-023 flush SHALL clear out_valid and block acceptance that cycle; scoreboard SHALL NOT be cleared (issued loads still land).
REQ-024 FSM states RUN, HALT_PEND, HALTED: RUN->HALT_PEND on accepting HLT; HALT_PEND->HALTED when HLT bundle consumed; HALT_PEND->RUN on flush; HALTED exits only on reset.
REQ-025 halted=1 only in HALTED; in_ready=0 in HALT_PEND and HALTED.
REQ-026 Reserved ops 0111/1110 SHALL decode with all enables 0, as NOP.

Reset
REQ-027 On rst_n=0: state RUN, out_valid=0, scoreboard all 0, halted=0, bundle all 0 except branch=111; in_ready rises the cycle after release.
REQ-028 Reset mid-operation SHALL discard held bundle and pending hazards without emitting them.

Configuration
REQ-029 Macro DECODE_CTL_IO_EN: defined -> IN/OUT decoded per REQ-012/013; undefined -> ops 1100/1101 decode as NOP, in_en/out_en tied 0.

Structure
REQ-030 Shared package decode_pkg SHALL hold class/op/branch-code constants, FSM state enum and the control-bundle struct.
REQ-031 Sub-module decode_scoreboard SHALL hold counters and hazard logic; decode is combinational inside decode_ctl.

Verification
REQ-032 ADD r1,r2 (inst 0xD100 class 11, f1=010, f2=001, op 0000) -> next cycle out_valid=1, reg_write=1, alu_src2=0, opcode=0000, reg_dst=001.
REQ-033 LD r3 then ADD reading r3 back-to-back, LOAD_LAT=2 -> in_ready=0 for 2 cycles, ADD accepted on cycle 3.
REQ-034 out_ready=0 for 4 cycles with valid bundle -> bundle fields stable, in_ready=0, no instruction lost.
REQ-035 HLT accepted, then flush before consume -> state RUN, halted=0; HLT consumed instead -> halted=1 and stays until rst_n=0.
REQ-036 Bcc f2=011 -> branch=011, branch_cond=1, alu_src1=1; op 1101 with DECODE_CTL_IO_EN undefined -> out_en=0, reg_write=0.
